fifo_burst_reader: RTL and testbench

Read-side controller for the team's FIFO modules. On a start command it drains a programmed number of words from the FIFO read port and presents them on a valid/ready stream, with a 2-entry skid buffer that absorbs the FIFO's 1-cycle read latency under backpressure. It sits between the read side of the FIFO (`o_rd_en`/`o_rdata`/`o_rempty`) and any downstream consumer, replacing ad-hoc read loops.

---
 rtl/fifo_burst_reader_if.sv | 33 +++
 rtl/fifo_burst_reader.sv | 132 +++++++++++++
 tb/tb_fifo_burst_reader.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_burst_reader_if.sv
// FIFO read port plus the outgoing valid/ready stream of the burst reader.
// master = the reader, slave = the FIFO/consumer side.
interface fifo_burst_reader_if #(
    parameter int P_DATA_WIDTH = 4
);
    logic                    o_rd_en;
    logic [P_DATA_WIDTH-1:0] i_rdata;
    logic                    i_rempty;
    logic [P_DATA_WIDTH-1:0] o_data;
    logic                    o_valid;
    logic                    o_last;
    logic                    i_ready;

    modport master (
        output o_rd_en,
        input  i_rdata,
        input  i_rempty,
        output o_data,
        output o_valid,
        output o_last,
        input  i_ready
    );

    modport slave (
        input  o_rd_en,
        output i_rdata,
        output i_rempty,
        input  o_data,
        input  o_valid,
        input  o_last,
        output i_ready
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a programmed number of words from a FIFO read port onto a valid/ready
// stream; a 2-entry skid buffer absorbs the FIFO's 1-cycle read latency.
module fifo_burst_reader #(
    parameter int P_DATA_WIDTH = 4,
    parameter int P_LEN_WIDTH  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [P_LEN_WIDTH-1:0] i_len,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [P_LEN_WIDTH-1:0] o_cnt,
    fifo_burst_reader_if.master    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [P_LEN_WIDTH-1:0]  len_q;
    logic [P_LEN_WIDTH-1:0]  issued_q;
    logic [P_LEN_WIDTH-1:0]  cnt_q;
    logic                    inflight_q;
    logic [1:0]              buf_cnt_q;
    logic [P_DATA_WIDTH-1:0] buf0_q;
    logic [P_DATA_WIDTH-1:0] buf1_q;

    logic       start_ok;
    logic       valid;
    logic       pop;
    logic       last_word;
    logic       last_pop;
    logic       rd_en;
    logic [2:0] occ_after;

    assign start_ok  = i_start && (i_len != '0);
    assign valid     = (buf_cnt_q != 2'd0);
    assign pop       = valid && bus.i_ready;
    assign last_word = (cnt_q == len_q - P_LEN_WIDTH'(1));
    assign last_pop  = pop && last_word;

    // Occupancy once this cycle's returning word lands and any pop leaves;
    // a new read is only safe if that leaves room for it.
    assign occ_after = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_ok) state_nxt = S_BURST;
            S_BURST: if (last_pop) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en  = 1'b0;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (state)
            S_BURST: begin
                o_busy = 1'b1;
                rd_en  = !bus.i_rempty && (issued_q < len_q) && (occ_after < 3'd2);
            end
            S_DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            len_q      <= '0;
            issued_q   <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            buf_cnt_q  <= 2'd0;
            buf0_q     <= '0;
            buf1_q     <= '0;
        end else begin
            inflight_q <= rd_en;
            if (state == S_IDLE && start_ok) begin
                len_q    <= i_len;
                issued_q <= '0;
                cnt_q    <= '0;
            end
            if (rd_en) issued_q <= issued_q + P_LEN_WIDTH'(1);
            if (pop)   cnt_q    <= cnt_q + P_LEN_WIDTH'(1);

            // buf0 is always the head; buf1 only holds a word behind it
            case ({inflight_q, pop})
                2'b10: begin
                    if (buf_cnt_q == 2'd0) buf0_q <= bus.i_rdata;
                    else                   buf1_q <= bus.i_rdata;
                    buf_cnt_q <= buf_cnt_q + 2'd1;
                end
                2'b01: begin
                    buf0_q    <= buf1_q;
                    buf_cnt_q <= buf_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt_q == 2'd1) begin
                        buf0_q <= bus.i_rdata;
                    end else begin
                        buf0_q <= buf1_q;
                        buf1_q <= bus.i_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_rd_en = rd_en;
    assign bus.o_valid = valid;
    assign bus.o_data  = buf0_q;
    assign bus.o_last  = valid && last_word;
    assign o_cnt       = cnt_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized scoreboard bench for fifo_burst_reader: a queue-based FIFO model
// feeds the DUT, a negedge monitor checks every stream handshake.
module tb_fifo_burst_reader;
    localparam int DW = 4;
    localparam int LW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic [LW-1:0] i_len;
    logic          o_busy;
    logic          o_done;
    logic [LW-1:0] o_cnt;

    fifo_burst_reader_if #(.P_DATA_WIDTH(DW)) bus ();

    fifo_burst_reader #(.P_DATA_WIDTH(DW), .P_LEN_WIDTH(LW)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_len   (i_len),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_cnt   (o_cnt),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- FIFO model: 1-cycle read latency ----------------
    logic [DW-1:0] fq[$];
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;

    always @(posedge i_clk) begin
        if (bus.o_rd_en === 1'b1 && fq.size() > 0) fifo_rdata <= fq.pop_front();
        if (wr_en) fq.push_back(wr_data);
        fifo_empty <= (fq.size() == 0);
    end

    assign bus.i_rempty = fifo_empty;
    assign bus.i_rdata  = fifo_rdata;

    // ---------------- downstream ready pattern ----------------
    int   rdy_mode = 0; // 0: held 1, 1: toggle, 2: random, 3: held 0
    logic ready_r  = 1'b1;

    always @(posedge i_clk) begin
        #2;
        case (rdy_mode)
            0:       ready_r = 1'b1;
            1:       ready_r = ~ready_r;
            2:       ready_r = 1'($urandom_range(0, 1));
            default: ready_r = 1'b0;
        endcase
    end

    assign bus.i_ready = ready_r;

    // ---------------- scoreboard + monitor ----------------
    logic [DW-1:0] exp_data_q[$];
    bit            exp_last_q[$];
    int            reads = 0;
    int            pops  = 0;
    int            occ   = 0;
    logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [DW-1:0] pd = '0;

    always @(negedge i_clk) begin
        if (i_rst) begin
            occ = 0;
            pv  = 1'b0;
        end else begin
            check("rd_en_while_empty", 32'(bus.o_rd_en && bus.i_rempty), 0);
            check("occupancy_le2", 32'(occ <= 2), 1);
            if (!bus.o_valid) check("last_without_valid", 32'(bus.o_last), 0);
            if (pv && !pr) begin
                check("hold_valid", 32'(bus.o_valid), 1);
                check("hold_data", 32'(bus.o_data), 32'(pd));
                check("hold_last", 32'(bus.o_last), 32'(pl));
            end
            if (bus.o_valid && bus.i_ready) begin
                if (exp_data_q.size() == 0 || exp_last_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got data %0d expected no word at %0t", bus.o_data, $time);
                end else begin
                    check("data", 32'(bus.o_data), 32'(exp_data_q.pop_front()));
                    check("last", 32'(bus.o_last), 32'(exp_last_q.pop_front()));
                end
                pops++;
                occ--;
            end
            if (bus.o_rd_en) begin
                reads++;
                occ++;
            end
            pv = bus.o_valid;
            pr = bus.i_ready;
            pd = bus.o_data;
            pl = bus.o_last;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        exp_data_q.push_back(w);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic preload_seq();
        for (int i = 1; i <= 16; i++) write_word(DW'(i));
    endtask

    task automatic write_random(input int n);
        for (int i = 0; i < n; i++) write_word(DW'($urandom));
    endtask

    task automatic do_start(input int len, input bit accept);
        if (accept) begin
            reads = 0;
            pops  = 0;
            for (int i = 0; i < len; i++) exp_last_q.push_back(i == len - 1);
        end
        i_start = 1'b1;
        i_len   = LW'(len);
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int len, input int max_cycles, input bit chk_time);
        int  n   = 0;
        bit  got = 0;
        while (n < max_cycles && !got) begin
            @(negedge i_clk);
            n++;
            if (o_done) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no o_done within %0d cycles expected done", max_cycles);
        end else begin
            checks++;
            if (chk_time) check("done_latency", 32'(n), 32'(len + 3));
            check("cnt_final", 32'(o_cnt), 32'(len));
            check("busy_at_done", 32'(o_busy), 1);
            check("reads_per_burst", 32'(reads), 32'(len));
            check("sb_drained", 32'(exp_last_q.size()), 0);
            @(negedge i_clk);
            check("busy_fall", 32'(o_busy), 0);
            check("done_pulse", 32'(o_done), 0);
        end
        tick();
    endtask

    task automatic check_reset_outputs();
        check("rst_rd_en", 32'(bus.o_rd_en), 0);
        check("rst_valid", 32'(bus.o_valid), 0);
        check("rst_data", 32'(bus.o_data), 0);
        check("rst_last", 32'(bus.o_last), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_cnt", 32'(o_cnt), 0);
    endtask

    int disc;
    int n;
    int len;

    initial begin
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_len   = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_reset_outputs();
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        tick();

        // basic drain at full rate
        rdy_mode = 0;
        preload_seq();
        do_start(16, 1);
        wait_done(16, 100, 1);

        // toggling backpressure
        rdy_mode = 1;
        preload_seq();
        do_start(16, 1);
        wait_done(16, 200, 0);

        // ready held low from the start
        rdy_mode = 3;
        tick();
        preload_seq();
        do_start(16, 1);
        repeat (10) @(negedge i_clk);
        check("held_reads", 32'(reads), 2);
        check("held_valid", 32'(bus.o_valid), 1);
        check("held_data", 32'(bus.o_data), 1);
        @(posedge i_clk);
        #1;
        rdy_mode = 0;
        wait_done(16, 100, 0);

        // FIFO runs empty mid-burst
        write_random(3);
        do_start(5, 1);
        repeat (8) @(negedge i_clk);
        check("stall_pops", 32'(pops), 3);
        check("stall_reads", 32'(reads), 3);
        check("stall_rd_en", 32'(bus.o_rd_en), 0);
        check("stall_busy", 32'(o_busy), 1);
        @(posedge i_clk);
        #1;
        write_random(2);
        wait_done(5, 50, 0);

        // zero-length start is ignored
        do_start(0, 0);
        repeat (3) begin
            @(negedge i_clk);
            check("len0_busy", 32'(o_busy), 0);
            check("len0_cnt", 32'(o_cnt), 5);
        end
        tick();

        // start during a burst is ignored
        write_random(6);
        do_start(6, 1);
        tick();
        do_start(2, 0);
        wait_done(6, 50, 0);

        // reset after the 4th word
        preload_seq();
        do_start(16, 1);
        n = 0;
        while (pops < 4 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        check("reset_reached_word4", 32'(pops >= 4), 1);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        @(negedge i_clk);
        check_reset_outputs();
        disc = exp_data_q.size() - fq.size();
        check("discard_le3", 32'(disc <= 3), 1);
        exp_data_q = fq;
        exp_last_q.delete();
        @(posedge i_clk);
        #1;
        do_start(4, 1);
        wait_done(4, 50, 1);

        // randomized bursts under random backpressure
        rdy_mode = 2;
        repeat (8) begin
            len = $urandom_range(1, 12);
            write_random(len);
            do_start(len, 1);
            wait_done(len, 300, 0);
        end

        rdy_mode = 0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
